// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches and buffers one instruction for IF/ID.
// Optional IFETCH_PERF_EN adds a saturating perf_issued count of instructions handed downstream.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_ins,
  output logic        if_enable,
  output logic [31:0] if_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_issued
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc, pc_nxt;
  logic [XLEN-1:0]   buf_ins, buf_ins_nxt;
  logic [XLEN-1:0]   buf_pc, buf_pc_nxt;
  logic              buf_valid, buf_valid_nxt;
  logic [XLEN-1:0]   redirect_tgt;

  // Low two bits are masked so the PC stays word aligned.
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      buf_ins   <= '0;
      buf_pc    <= '0;
      buf_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      buf_ins   <= buf_ins_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_valid <= buf_valid_nxt;
    end
  end

  // Redirect wins over everything; a stalled HOLD drops the request so no ack can land.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    buf_ins_nxt   = buf_ins;
    buf_pc_nxt    = buf_pc;
    buf_valid_nxt = buf_valid;
    imem_req      = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = FETCH;
        if (redirect) pc_nxt = redirect_tgt;
      end
      FETCH, HOLD: begin
        if (redirect) begin
          pc_nxt        = redirect_tgt;
          buf_valid_nxt = 1'b0;
          state_nxt     = FETCH;
        end else if (state == FETCH || !stall) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            buf_ins_nxt   = imem_rdata;
            buf_pc_nxt    = pc;
            buf_valid_nxt = 1'b1;
            pc_nxt        = pc + XLEN'(PC_STEP);
            state_nxt     = HOLD;
          end else begin
            buf_valid_nxt = 1'b0;
            state_nxt     = FETCH;
          end
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_addr = pc;
  assign if_ins    = buf_ins;
  assign if_pc     = buf_pc;
  assign if_enable = buf_valid;

`ifdef IFETCH_PERF_EN
  // Counts hand-offs: a held instruction leaves whenever downstream accepts and no flush occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued <= '0;
    end else if (state == HOLD && !stall && !redirect && perf_issued != '1) begin
      perf_issued <= perf_issued + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized phase, checked against a
// stream-level model of the fetch contract (which PC is delivered next, when a request is legal).
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] SALT     = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_ins;
  logic        if_enable;
  logic [31:0] if_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_issued;
`endif

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_ins      (if_ins),
    .if_enable   (if_enable),
    .if_pc       (if_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_issued (perf_issued)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: 0 = zero-wait, 1 = ack on 3rd request cycle, 2 = random; force_ack ignores req.
  logic [1:0]  mem_mode;
  int unsigned lat_cnt;
  logic        rnd_ack;
  logic        force_ack;
  assign imem_ack   = force_ack | (imem_req & ((mem_mode == 2'd0) ? 1'b1 :
                                              (mem_mode == 2'd1) ? (lat_cnt >= 2) : rnd_ack));
  assign imem_rdata = imem_addr ^ SALT;

  // Stream-level model: next PC to fetch, and the instruction currently presented downstream.
  logic        m_boot;
  logic        m_valid;
  logic [31:0] m_next;
  logic [31:0] m_ins;
  logic [31:0] m_bpc;
  logic [31:0] m_perf;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_valid = 1'b0;
    m_next  = RESET_PC;
    m_ins   = '0;
    m_bpc   = '0;
    m_perf  = '0;
    lat_cnt = 0;
  endtask

  // One clock: check request side before the edge, advance the model, check outputs after it.
  task automatic cycle();
    logic        exp_req;
    logic        s_req;
    logic        s_ack;
    logic [31:0] tgt;
    #2;
    exp_req = !m_boot && !redirect && !(m_valid && stall);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("imem_addr", imem_addr, m_next);
    s_req = imem_req;
    s_ack = imem_ack;
    tgt   = {redirect_pc[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (!m_boot && m_valid && !stall && !redirect && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
    if (m_boot) begin
      m_boot = 1'b0;
      if (redirect) m_next = tgt;
    end else if (redirect) begin
      m_next  = tgt;
      m_valid = 1'b0;
    end else if (exp_req && s_ack) begin
      m_ins   = m_next ^ SALT;
      m_bpc   = m_next;
      m_valid = 1'b1;
      m_next  = m_next + 32'd4;
    end else if (m_valid && !stall) begin
      m_valid = 1'b0;
    end
    if (s_req && s_ack) lat_cnt = 0;
    else if (s_req)     lat_cnt = lat_cnt + 1;
    else                lat_cnt = 0;
    rnd_ack = 1'($urandom_range(0, 1));
    check("if_enable", 32'(if_enable), 32'(m_valid));
    check("if_pc", if_pc, m_bpc);
    check("if_ins", if_ins, m_ins);
`ifdef IFETCH_PERF_EN
    check("perf_issued", perf_issued, m_perf);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_ins"}, if_ins, 32'd0);
    check({tag, "_en"}, 32'(if_enable), 32'd0);
    check({tag, "_pc"}, if_pc, 32'd0);
`ifdef IFETCH_PERF_EN
    check({tag, "_perf"}, perf_issued, 32'd0);
`endif
  endtask

  // Holds reset across an edge, then releases it 1 time unit after a rising edge.
  task automatic reset_and_release();
    reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_mode    = 2'd0;
    force_ack   = 1'b0;
    rnd_ack     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_and_release();

    // Zero-wait memory: first request after the boot cycle, then one instruction per cycle.
    cycle();
    cycle();
    check("first_pc", if_pc, 32'h0000_3000);
    check("first_ins", if_ins, 32'h0000_3000 ^ SALT);
    cycle();
    check("second_pc", if_pc, 32'h0000_3004);
    cycle();
    check("third_pc", if_pc, 32'h0000_3008);

    // Stall holds the buffered instruction and drops the request.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_pc", if_pc, 32'h0000_3008);
      check("stall_en", 32'(if_enable), 32'd1);
    end
    stall = 1'b0;
    cycle();
    check("resume_pc", if_pc, 32'h0000_300C);

    // Three-cycle latency memory: one delivery every third cycle, no PC skipped.
    mem_mode = 2'd1;
    for (int i = 0; i < 9; i++) cycle();
    check("lat_pc", if_pc, 32'h0000_3018);
    check("lat_en", 32'(if_enable), 32'd1);

    // Redirect with a coincident ack: ack discarded, misaligned target rounded down.
    mem_mode    = 2'd0;
    redirect    = 1'b1;
    force_ack   = 1'b1;
    redirect_pc = 32'h0000_4003;
    cycle();
    check("redir_flush", 32'(if_enable), 32'd0);
    redirect  = 1'b0;
    force_ack = 1'b0;
    cycle();
    check("redir_pc", if_pc, 32'h0000_4000);

    // PC wraps modulo 2^32.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
    cycle();
    check("wrap_pc1", if_pc, 32'h0000_0000);
    cycle();
    check("wrap_pc2", if_pc, 32'h0000_0004);

    // Reset mid-fetch with an ack pending: outputs clear without waiting for an edge.
    mem_mode = 2'd1;
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    mem_mode = 2'd0;
    reset_and_release();
    cycle();
    cycle();
    check("refetch_pc", if_pc, 32'h0000_3000);

    // Redirect during the boot cycle still steers the first fetch.
    reset_and_release();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5002;
    cycle();
    redirect = 1'b0;
    cycle();
    check("boot_redir_pc", if_pc, 32'h0000_5000);

    // Randomized traffic against the model.
    mem_mode = 2'd2;
    for (int i = 0; i < 800; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      force_ack   = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
